bcd_scan_mux: RTL and testbench

- Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
- Accepts a packed BCD value and double-buffers it so the display never tears mid-frame.
- Each digit slot drives one active-low anode and presents that digit's nibble to the downstream single-digit 7-segment decoder.
- Sits between the measurement/status logic (frame counters, FPS readout) and the decoder.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/scan_prescaler.sv | 29 ++
 rtl/bcd_scan_mux.sv | 134 +++++++++++++
 tb/tb_bcd_scan_mux.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and digit helpers for the 7-segment scanner
package disp_pkg;

    localparam int DIGIT_W        = 4;
    localparam int BCD_MAX        = 9;
    localparam int NUM_DIGITS_DEF = 8;
    localparam int MAX_DIGITS     = 32;
    localparam int MSD_W          = 5;

    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Index of the highest nonzero nibble; 0 when the whole value is zero.
    function automatic logic [MSD_W-1:0] msd_index(input logic [MAX_DIGITS*DIGIT_W-1:0] v);
        logic [MSD_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] != '0) begin
                r = MSD_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - divides the system clock down to one tick per digit slot
module scan_prescaler #(
    parameter int DIV_CNT = 100000
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iEnable,
    output logic oTick
);

    localparam int                CNT_W    = $clog2(DIV_CNT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_CNT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign oTick = iEnable && (r_cnt == CNT_LAST);

    // Holding the count while disabled lets a frozen slot finish its full dwell later.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cnt <= '0;
        end else if (oTick) begin
            r_cnt <= '0;
        end else if (iEnable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_scan_mux.sv
// rtl/bcd_scan_mux.sv - double-buffered 8-digit anode scanner; LEADING_ZERO_BLANK_EN blanks leading zeros
module bcd_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int DIV_CNT    = 100000
) (
    input  logic                          iClk,
    input  logic                          iRst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] iValue,
    input  logic                          iLoad,
    input  logic                          iEnable,
    output logic [DIGIT_W-1:0]            oDigit,
    output logic [NUM_DIGITS-1:0]         oAn,
    output logic                          oBadBcd,
    output logic                          oFrame
);

    localparam int                     IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0]  AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];
    localparam logic [DIGIT_W-1:0]     NIB_MAX    = DIGIT_W'(BCD_MAX);

    logic                          w_tick;
    logic                          w_wrap;
    logic                          w_blank;
    logic                          w_nib_bad;
    logic [DIGIT_W-1:0]            w_nib;
    logic [NUM_DIGITS-1:0]         w_an_sel;

    logic [IDX_W-1:0]              r_idx;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_shadow;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_active;
    logic                          r_pending;
    logic [NUM_DIGITS-1:0]         r_an;
    logic [DIGIT_W-1:0]            r_digit;
    logic                          r_bad;
    logic                          r_frame;

    scan_prescaler #(
        .DIV_CNT (DIV_CNT)
    ) u_prescaler (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iEnable (iEnable),
        .oTick   (w_tick)
    );

    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= w_wrap ? '0 : r_idx + 1'b1;
        end
    end

    // A load landing on the wrap cycle bypasses the shadow so it is not deferred a frame.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (iLoad) begin
                r_shadow <= iValue;
            end
            if (w_wrap) begin
                if (iLoad) begin
                    r_active <= iValue;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
                r_pending <= 1'b0;
            end else if (iLoad) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_nib    = '0;
        w_an_sel = AN_ALL_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_active[i*DIGIT_W +: DIGIT_W];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    assign w_nib_bad = (w_nib > NIB_MAX);

`ifdef LEADING_ZERO_BLANK_EN
    logic [MAX_DIGITS*DIGIT_W-1:0] w_act_ext;
    logic [MSD_W-1:0]              w_msd;

    always_comb begin
        w_act_ext                       = '0;
        w_act_ext[DIGIT_W*NUM_DIGITS-1:0] = r_active;
    end

    assign w_msd   = msd_index(w_act_ext);
    assign w_blank = (MSD_W'(r_idx) > w_msd);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_an    <= AN_ALL_OFF;
            r_digit <= '0;
            r_bad   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            r_bad   <= iEnable && w_nib_bad;
            if (iEnable && !w_blank) begin
                r_an    <= w_an_sel;
                r_digit <= w_nib_bad ? '0 : w_nib;
            end else begin
                r_an    <= AN_ALL_OFF;
                r_digit <= '0;
            end
        end
    end

    assign oAn     = r_an;
    assign oDigit  = r_digit;
    assign oBadBcd = r_bad;
    assign oFrame  = r_frame;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// tb/tb_bcd_scan_mux.sv - self-checking bench for bcd_scan_mux
module tb_bcd_scan_mux;

    localparam int ND    = 8;
    localparam int DIV   = 4;
    localparam int FRAME = ND * DIV;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic [31:0] iValue;
    logic        iLoad;
    logic        iEnable;
    logic [3:0]  oDigit;
    logic [7:0]  oAn;
    logic        oBadBcd;
    logic        oFrame;

    bcd_scan_mux #(
        .NUM_DIGITS (ND),
        .DIV_CNT    (DIV)
    ) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iValue  (iValue),
        .iLoad   (iLoad),
        .iEnable (iEnable),
        .oDigit  (oDigit),
        .oAn     (oAn),
        .oBadBcd (oBadBcd),
        .oFrame  (oFrame)
    );

    always #5 iClk = ~iClk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: slot position derived from the number of enabled cycles since reset.
    int unsigned m_ecnt;
    logic [31:0] m_active;
    logic [31:0] m_pval;
    bit          m_pend;
    bit          m_wrap;
    logic [7:0]  e_an;
    logic [3:0]  e_dig;
    bit          e_bad;
    bit          e_frame;

    typedef struct {
        logic [31:0] val;
        int          slot;
        logic [3:0]  dig;
        logic [7:0]  an;
        logic        bad;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ecnt   = 0;
        m_active = '0;
        m_pval   = '0;
        m_pend   = 1'b0;
        m_wrap   = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input logic [31:0] v);
        int         idx;
        int         msd;
        logic [3:0] n;
        bit         blank;
        idx = int'((m_ecnt / DIV) % ND);
        n   = m_active[idx*4 +: 4];
        msd = 0;
        for (int i = 0; i < ND; i++) begin
            if (m_active[i*4 +: 4] != 4'd0) msd = i;
        end
        blank   = BLANK && (idx > msd);
        m_wrap  = en && (((m_ecnt + 1) % FRAME) == 0);
        e_frame = m_wrap;
        e_an    = (en && !blank) ? ~(8'h01 << idx) : 8'hFF;
        e_dig   = (en && !blank && n <= 4'd9) ? n : 4'd0;
        e_bad   = en && (n > 4'd9);
        if (m_wrap) begin
            if (ld)          m_active = v;
            else if (m_pend) m_active = m_pval;
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
            m_pval = v;
        end
        if (en) m_ecnt++;
    endtask

    task automatic step(input bit en, input bit ld, input logic [31:0] v);
        iEnable = en;
        iLoad   = ld;
        iValue  = v;
        @(posedge iClk);
        model_edge(en, ld, v);
        @(negedge iClk);
        chk("an", {24'd0, oAn}, {24'd0, e_an});
        chk("digit", {28'd0, oDigit}, {28'd0, e_dig});
        chk("bad", {31'd0, oBadBcd}, {31'd0, e_bad});
        chk("frame", {31'd0, oFrame}, {31'd0, e_frame});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            step(1'b1, 1'b0, 32'd0);
            k++;
        end while (!m_wrap && k < 2 * FRAME);
        if (!m_wrap) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        #2 iRst_n = 1'b0;
        #1;
        chk("rst_an", {24'd0, oAn}, 32'hFF);
        chk("rst_digit", {28'd0, oDigit}, 32'd0);
        chk("rst_bad", {31'd0, oBadBcd}, 32'd0);
        chk("rst_frame", {31'd0, oFrame}, 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        if ($urandom_range(0, 1) == 0) begin
            v = $urandom;
        end else begin
            v = '0;
            for (int i = 0; i < ND; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 7));
        end
        return v;
    endfunction

    initial begin
        int   k;
        bit   r_en;
        bit   r_ld;
        logic [31:0] r_v;

        tbl[0]  = '{32'h12345678, 0, 4'd8, 8'hFE, 1'b0};
        tbl[1]  = '{32'h12345678, 7, 4'd1, 8'h7F, 1'b0};
        tbl[2]  = '{32'h0000000A, 0, 4'd0, 8'hFE, 1'b1};
        tbl[3]  = '{32'h0000000A, 1, 4'd0, BLANK ? 8'hFF : 8'hFD, 1'b0};
        tbl[4]  = '{32'h99999999, 4, 4'd9, 8'hEF, 1'b0};
        tbl[5]  = '{32'hF0000000, 7, 4'd0, 8'h7F, 1'b1};
        tbl[6]  = '{32'hF0000000, 3, 4'd0, 8'hF7, 1'b0};
        tbl[7]  = '{32'h00000042, 1, 4'd4, 8'hFD, 1'b0};
        tbl[8]  = '{32'h00000042, 2, 4'd0, BLANK ? 8'hFF : 8'hFB, 1'b0};
        tbl[9]  = '{32'h00000000, 0, 4'd0, 8'hFE, 1'b0};
        tbl[10] = '{32'h00000000, 5, 4'd0, BLANK ? 8'hFF : 8'hDF, 1'b0};
        tbl[11] = '{32'h90817263, 5, 4'd8, 8'hDF, 1'b0};

        iRst_n  = 1'b0;
        iEnable = 1'b1;
        iLoad   = 1'b0;
        iValue  = '0;
        model_reset();

        // Reset state and first slot after release
        @(posedge iClk);
        @(negedge iClk);
        chk("t1_rst_an", {24'd0, oAn}, 32'hFF);
        chk("t1_rst_digit", {28'd0, oDigit}, 32'd0);
        iRst_n = 1'b1;
        step(1'b1, 1'b0, 32'd0);
        chk("t1_an_fe", {24'd0, oAn}, 32'hFE);
        run(4);
        chk("t1_an_fd", {24'd0, oAn}, 32'hFD);

        // Load during slot 3 is held until the frame boundary
        k = 0;
        while (((m_ecnt / DIV) % ND) != 3 && k < 2 * FRAME) begin
            step(1'b1, 1'b0, 32'd0);
            k++;
        end
        step(1'b1, 1'b1, 32'h12345678);
        wait_frame();
        step(1'b1, 1'b0, 32'd0);
        chk("t2_slot0_digit", {28'd0, oDigit}, 32'd8);
        chk("t2_slot0_an", {24'd0, oAn}, 32'hFE);
        run(28);
        chk("t2_slot7_digit", {28'd0, oDigit}, 32'd1);
        chk("t2_slot7_an", {24'd0, oAn}, 32'h7F);

        for (int t = 0; t < 12; t++) begin
            step(1'b1, 1'b1, tbl[t].val);
            wait_frame();
            run(1 + DIV * tbl[t].slot);
            chk($sformatf("tbl%0d_digit", t), {28'd0, oDigit}, {28'd0, tbl[t].dig});
            chk($sformatf("tbl%0d_an", t), {24'd0, oAn}, {24'd0, tbl[t].an});
            chk($sformatf("tbl%0d_bad", t), {31'd0, oBadBcd}, {31'd0, tbl[t].bad});
        end

        // Load on the exact wrap cycle commits directly and clears pending
        step(1'b1, 1'b1, 32'h11111111);
        k = 0;
        while ((((m_ecnt + 1) % FRAME) != 0) && k < 2 * FRAME) begin
            step(1'b1, 1'b0, 32'd0);
            k++;
        end
        step(1'b1, 1'b1, 32'h99999999);
        chk("t4_pending", {31'd0, dut.r_pending}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("t4_slot0_digit", {28'd0, oDigit}, 32'd9);

        // Freeze during slot 5, then resume the remaining dwell
        k = 0;
        while ((m_ecnt % FRAME) != (5 * DIV + 1) && k < 2 * FRAME) begin
            step(1'b1, 1'b0, 32'd0);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("t5_dark_an", {24'd0, oAn}, 32'hFF);
            chk("t5_dark_frame", {31'd0, oFrame}, 32'd0);
        end
        step(1'b1, 1'b0, 32'd0);
        chk("t5_resume_an", {24'd0, oAn}, 32'hDF);
        run(2);
        chk("t5_last_an", {24'd0, oAn}, 32'hDF);
        run(1);
        chk("t5_next_an", {24'd0, oAn}, 32'hBF);

        // Reset mid-frame drops a pending load
        step(1'b1, 1'b1, 32'h55555555);
        do_reset();
        run(FRAME + 8);
        chk("t7_after_rst_digit", {28'd0, oDigit}, 32'd0);

        for (int c = 0; c < 1500; c++) begin
            r_en = ($urandom_range(0, 9) != 0);
            r_ld = ($urandom_range(0, 11) == 0);
            r_v  = rnd_val();
            if ($urandom_range(0, 399) == 0) do_reset();
            else step(r_en, r_ld, r_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
